// File: rtl/dm_sb_target_pkg.sv
// Shared types and constants for the system-bus target responder.
package dm_sb_target_pkg;

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        GntWait = 2'd1,
        RspWait = 2'd2
    } target_state_e;

    localparam int MaxTargetDelay = 15;
    localparam int DelayCntWidth  = $clog2(MaxTargetDelay + 1);

endpackage

// File: rtl/dm_sb_target_if.sv
// Single-beat req/gnt bus with one r_valid response per grant.
interface dm_sb_target_if #(
    parameter int BusWidth = 32
) ();

    logic                    req;
    logic [BusWidth-1:0]     add;
    logic                    we;
    logic [BusWidth-1:0]     wdata;
    logic [BusWidth/8-1:0]   be;
    logic                    gnt;
    logic                    r_valid;
    logic [BusWidth-1:0]     r_rdata;
    logic                    r_err;

    modport master (
        output req, add, we, wdata, be,
        input  gnt, r_valid, r_rdata, r_err
    );

    modport slave (
        input  req, add, we, wdata, be,
        output gnt, r_valid, r_rdata, r_err
    );

endinterface

// File: rtl/dm_sb_target_mem.sv
// Word-addressed flop memory with byte-enable write and registered read.
// The read port samples the pre-write contents on the same edge as a write.
module dm_sb_target_mem #(
    parameter int BusWidth = 32,
    parameter int NumWords = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        i_wr_en,
    input  logic                        i_rd_en,
    input  logic                        i_rd_zero,
    input  logic [$clog2(NumWords)-1:0] i_idx,
    input  logic [BusWidth-1:0]         i_wdata,
    input  logic [BusWidth/8-1:0]       i_be,
    output logic [BusWidth-1:0]         o_rdata
);

    localparam int NumBytes = BusWidth / 8;

    logic [BusWidth-1:0] r_mem [NumWords];
    logic [BusWidth-1:0] r_rdata;

    // Memory array and read register; everything clears on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NumWords; w++) begin
                r_mem[w] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_wr_en) begin
                for (int b = 0; b < NumBytes; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end
            if (i_rd_en) begin
                r_rdata <= i_rd_zero ? '0 : r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_sb_target.sv
// System-bus target: grants single requests after GntDelay cycles and
// returns one response beat RspDelay cycles after the grant.
//
// state   | meaning
// Idle    | no transaction; grant immediately when GntDelay is 0
// GntWait | request seen, counting down to the grant
// RspWait | command captured, counting down to the response beat
module dm_sb_target
    import dm_sb_target_pkg::*;
#(
    parameter int BusWidth = 32,
    parameter int NumWords = 16,
    parameter int GntDelay = 0,
    parameter int RspDelay = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    dm_sb_target_if.slave   bus
);

    localparam int ByteOffW = $clog2(BusWidth / 8);
    localparam int IdxW     = $clog2(NumWords);
    localparam logic [BusWidth-1:0]      AddrLimit = BusWidth'(NumWords * (BusWidth / 8));
    localparam logic [DelayCntWidth-1:0] GntLoad   = DelayCntWidth'(GntDelay - 1);
    localparam logic [DelayCntWidth-1:0] RspLoad   = DelayCntWidth'(RspDelay - 1);

    target_state_e              r_state;
    target_state_e              w_state_nxt;
    logic [DelayCntWidth-1:0]   r_cnt;
    logic [DelayCntWidth-1:0]   w_cnt_nxt;
    logic                       w_gnt;
    logic                       w_valid_nxt;
    logic                       r_valid;
    logic                       r_err;
    logic                       w_err;
    logic                       w_wr_en;
    logic [IdxW-1:0]            w_idx;
    logic [BusWidth-1:0]        w_rdata;

    assign w_idx   = bus.add[ByteOffW +: IdxW];
    assign w_err   = (bus.add >= AddrLimit);
    assign w_wr_en = w_gnt & bus.we & ~w_err;

    // Next state, counter and grant; the beat is flagged one cycle early so
    // r_valid can come straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt       = 1'b0;
        unique case (r_state)
            Idle: begin
                if (bus.req) begin
                    if (GntDelay == 0) begin
                        w_gnt       = 1'b1;
                        w_state_nxt = RspWait;
                        w_cnt_nxt   = RspLoad;
                    end else begin
                        w_state_nxt = GntWait;
                        w_cnt_nxt   = GntLoad;
                    end
                end
            end
            GntWait: begin
                if (!bus.req) begin
                    w_state_nxt = Idle;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_gnt       = 1'b1;
                    w_state_nxt = RspWait;
                    w_cnt_nxt   = RspLoad;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            RspWait: begin
                if (r_cnt == '0) begin
                    w_state_nxt = Idle;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = Idle;
                w_cnt_nxt   = '0;
            end
        endcase
        w_valid_nxt = (w_state_nxt == RspWait) && (w_cnt_nxt == '0);
    end

    // State, counter, response strobe and error flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= Idle;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            if (w_gnt) begin
                r_err <= w_err;
            end
        end
    end

    dm_sb_target_mem #(
        .BusWidth (BusWidth),
        .NumWords (NumWords)
    ) u_mem (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_wr_en   (w_wr_en),
        .i_rd_en   (w_gnt),
        .i_rd_zero (w_err),
        .i_idx     (w_idx),
        .i_wdata   (bus.wdata),
        .i_be      (bus.be),
        .o_rdata   (w_rdata)
    );

    assign bus.gnt     = w_gnt;
    assign bus.r_valid = r_valid;
    assign bus.r_rdata = w_rdata;
    assign bus.r_err   = r_err;

    a_gnt_delay_range: assert property (@(posedge clk_i)
        (GntDelay >= 0) && (GntDelay <= MaxTargetDelay));
    a_rsp_delay_range: assert property (@(posedge clk_i)
        (RspDelay >= 1) && (RspDelay <= MaxTargetDelay));
    a_num_words_pow2: assert property (@(posedge clk_i)
        (NumWords >= 2) && ((NumWords & (NumWords - 1)) == 0));
    a_bus_width: assert property (@(posedge clk_i)
        (BusWidth == 32) || (BusWidth == 64));
    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == GntWait) |-> bus.req);

endmodule

// File: tb/tb_dm_sb_target.sv
// Directed bench: DUT A with GntDelay=0/RspDelay=1, DUT B with 3/4.
module tb_dm_sb_target;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    dm_sb_target_if #(.BusWidth(32)) bus_a ();
    dm_sb_target_if #(.BusWidth(32)) bus_b ();

    dm_sb_target #(.BusWidth(32), .NumWords(16), .GntDelay(0), .RspDelay(1)) u_dut_a (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_a)
    );

    dm_sb_target #(.BusWidth(32), .NumWords(16), .GntDelay(3), .RspDelay(4)) u_dut_b (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_b)
    );

    task automatic drive(input bit sel, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        if (sel) begin
            bus_b.req = req; bus_b.we = we; bus_b.add = addr; bus_b.wdata = wdata; bus_b.be = be;
        end else begin
            bus_a.req = req; bus_a.we = we; bus_a.add = addr; bus_a.wdata = wdata; bus_a.be = be;
        end
    endtask

    function automatic logic gnt_of(input bit sel);
        return sel ? bus_b.gnt : bus_a.gnt;
    endfunction

    function automatic logic rvalid_of(input bit sel);
        return sel ? bus_b.r_valid : bus_a.r_valid;
    endfunction

    function automatic logic [31:0] rdata_of(input bit sel);
        return sel ? bus_b.r_rdata : bus_a.r_rdata;
    endfunction

    function automatic logic err_of(input bit sel);
        return sel ? bus_b.r_err : bus_a.r_err;
    endfunction

    // One transaction; called at a cycle start, returns at the cycle start
    // after the beat. Cycle numbers are -1 when the wait expired.
    task automatic txn(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rdata, output logic err,
                       output int gnt_cyc, output int rv_cyc);
        gnt_cyc = -1;
        rv_cyc  = -1;
        rdata   = 32'hxxxx_xxxx;
        err     = 1'bx;
        drive(sel, 1'b1, we, addr, wdata, be);
        for (int i = 0; i < 40 && gnt_cyc < 0; i++) begin
            @(negedge clk_i);
            if (gnt_of(sel)) gnt_cyc = cyc;
        end
        @(posedge clk_i); #1;
        drive(sel, 1'b0, 1'b0, '0, '0, '0);
        if (gnt_cyc >= 0) begin
            for (int i = 0; i < 40 && rv_cyc < 0; i++) begin
                @(negedge clk_i);
                if (rvalid_of(sel)) begin
                    rv_cyc = cyc;
                    rdata  = rdata_of(sel);
                    err    = err_of(sel);
                end
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        checks++; if (bus_a.gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt_a: got %b want 0", bus_a.gnt); end
        checks++; if (bus_a.r_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid_a: got %b want 0", bus_a.r_valid); end
        checks++; if (bus_a.r_err !== 1'b0) begin errors++; $display("FAIL reset_err_a: got %b want 0", bus_a.r_err); end
        checks++; if (bus_a.r_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata_a: got %h want 0", bus_a.r_rdata); end
        checks++; if (bus_b.gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt_b: got %b want 0", bus_b.gnt); end
        checks++; if (bus_b.r_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid_b: got %b want 0", bus_b.r_valid); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_basic_read();
        logic [31:0] rd; logic er; int g, v, s;
        s = cyc;
        txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, g, v);
        checks++; if (g !== s) begin errors++; $display("FAIL basic_gnt_cycle: got %0d want %0d", g, s); end
        checks++; if (v !== s + 1) begin errors++; $display("FAIL basic_rvalid_cycle: got %0d want %0d", v, s + 1); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL basic_rdata: got %h want 0", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", er); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int g, v;
        txn(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 4'b1111, rd, er, g, v);
        checks++; if (er !== 1'b0 || v !== g + 1) begin errors++; $display("FAIL be_write_full: err %b lat %0d want err 0 lat 1", er, v - g); end
        txn(1'b0, 1'b1, 32'h8, 32'h000000AA, 4'b0001, rd, er, g, v);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL be_write_byte0: err %b want 0", er); end
        txn(1'b0, 1'b0, 32'h8, 32'h0, 4'b0000, rd, er, g, v);
        checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be_read_merge: got %h want deadbeaa", rd); end
        txn(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, rd, er, g, v);
        txn(1'b0, 1'b0, 32'h8, 32'h0, 4'b0000, rd, er, g, v);
        checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be_zero_noop: got %h want deadbeaa", rd); end
        txn(1'b0, 1'b1, 32'h8, 32'h12345678, 4'b1010, rd, er, g, v);
        txn(1'b0, 1'b0, 32'h8, 32'h0, 4'b0000, rd, er, g, v);
        checks++; if (rd !== 32'h12AD56AA) begin errors++; $display("FAIL be_sparse: got %h want 12ad56aa", rd); end
    endtask

    task automatic test_latency();
        int s;
        s = cyc;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk_i);
            checks++;
            if (bus_b.gnt !== (k == 3)) begin errors++; $display("FAIL lat_gnt@+%0d: got %b want %b", k, bus_b.gnt, (k == 3)); end
            checks++;
            if (bus_b.r_valid !== (k == 7)) begin errors++; $display("FAIL lat_rvalid@+%0d: got %b want %b", k, bus_b.r_valid, (k == 7)); end
            if (k == 7) begin
                checks++;
                if (bus_b.r_rdata !== 32'h0 || bus_b.r_err !== 1'b0) begin
                    errors++; $display("FAIL lat_beat: rdata %h err %b want 0 0", bus_b.r_rdata, bus_b.r_err);
                end
            end
            @(posedge clk_i); #1;
            if (k == 7) drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        end
        if (cyc != s + 11) $display("note: latency window drifted");
    endtask

    task automatic test_error();
        logic [31:0] rd; logic er; int g, v;
        txn(1'b0, 1'b1, 32'h0, 32'h11112222, 4'hF, rd, er, g, v);
        txn(1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, rd, er, g, v);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_write_flag: got %b want 1", er); end
        txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, g, v);
        checks++; if (rd !== 32'h11112222 || er !== 1'b0) begin errors++; $display("FAIL err_write_dropped: got %h err %b want 11112222 0", rd, er); end
        txn(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, g, v);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_read_data: got %h want 0", rd); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_read_flag: got %b want 1", er); end
        txn(1'b0, 1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, rd, er, g, v);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL err_last_word_write: got %b want 0", er); end
        txn(1'b0, 1'b0, 32'h3F, 32'h0, 4'h0, rd, er, g, v);
        checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL err_last_word_read: got %h err %b want cafef00d 0", rd, er); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int g1, v1, g2, v2;
        txn(1'b0, 1'b1, 32'h4, 32'h00000055, 4'hF, rd, er, g1, v1);
        txn(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, g2, v2);
        checks++; if (g2 !== g1 + 2 || g1 < 0) begin errors++; $display("FAIL b2b_turnaround: got %0d want 2", g2 - g1); end
        checks++; if (rd !== 32'h00000055 || er !== 1'b0) begin errors++; $display("FAIL b2b_rdata: got %h err %b want 55 0", rd, er); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int g, v;
        txn(1'b1, 1'b1, 32'hC, 32'h00000077, 4'hF, rd, er, g, v);
        checks++; if (v !== g + 4 || g < 0) begin errors++; $display("FAIL mid_write_latency: got %0d want 4", v - g); end
        txn(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, g, v);
        checks++; if (rd !== 32'h77) begin errors++; $display("FAIL mid_readback: got %h want 77", rd); end
        g = -1;
        drive(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
        for (int i = 0; i < 20 && g < 0; i++) begin
            @(negedge clk_i);
            if (bus_b.gnt) g = cyc;
        end
        checks++; if (g < 0) begin errors++; $display("FAIL mid_gnt_timeout: got none want gnt"); end
        @(posedge clk_i); #1;
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            checks++;
            if (bus_b.r_valid !== 1'b0) begin errors++; $display("FAIL mid_rvalid@+%0d: got %b want 0", k, bus_b.r_valid); end
            @(posedge clk_i); #1;
            if (k == 1) rst_ni = 1'b1;
        end
        txn(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, g, v);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL mid_cleared_b: got %h err %b want 0 0", rd, er); end
        txn(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, g, v);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL mid_cleared_a: got %h err %b want 0 0", rd, er); end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_byte_enable();
        test_latency();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
